memory_read_arbiter: RTL and testbench

- Parametrised successor to the single-channel memory read port.
- Merges NUM_CH independent read requestors (e.g. fetch, LSU, page walker) onto one physical memory read port.
- Arbitration is round-robin with a ready/valid-style request handshake. Up to MAX_OUTSTANDING reads may be in flight.
- In-order responses are routed back to the issuing channel through a tag FIFO, with a registered response stage.

---
 rtl/memory_read_arbiter.sv | 94 +++++++++
 tb/tb_memory_read_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_arbiter.sv
// memory_read_arbiter: round-robin merge of NUM_CH read requestors onto one memory read port with in-order response routing
module memory_read_arbiter #(
   parameter int NUM_CH          = 2,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_CH-1:0]                  ch_rd_en,
   input  logic [NUM_CH*ADDR_W-1:0]           ch_rd_addr,
   output logic [NUM_CH-1:0]                  ch_rd_ready,
   output logic [DATA_W-1:0]                  ch_rd_data,
   output logic [NUM_CH-1:0]                  ch_rd_valid,
   output logic                               mem_rd_en,
   output logic [ADDR_W-1:0]                  mem_rd_addr,
   input  logic                               mem_rd_ready,
   input  logic [DATA_W-1:0]                  mem_rd_data,
   input  logic                               mem_rd_valid,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
   output logic                               resp_err
);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;
   localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   logic [IW-1:0]     rr_q, rr_d, win_id, idx;
   logic [IW-1:0]     tags_q [MAX_OUTSTANDING];
   logic [PW-1:0]     wr_q, rd_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NUM_CH-1:0] vld_q, vld_d, elig;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic              err_q, err_d, full, win, accept, pop;

   // pick the first eligible channel at or after the round-robin pointer
   always_comb begin
      full = cnt_q == CW'(MAX_OUTSTANDING);
      elig = full ? '0 : ch_rd_en;
      win = 1'b0;
      win_id = '0;
      idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = IW'((int'(rr_q) + k) % NUM_CH);
         if (!win && elig[idx]) begin
            win = 1'b1;
            win_id = idx;
         end
      end
   end

   // handshake, tag-FIFO bookkeeping and registered response stage next state
   always_comb begin
      accept = win & mem_rd_ready;
      pop = mem_rd_valid & (cnt_q != '0);
      rr_d = accept ? (win_id == IW'(NUM_CH - 1) ? '0 : win_id + 1'b1) : rr_q;
      cnt_d = cnt_q + CW'(accept) - CW'(pop);
      vld_d = pop ? NUM_CH'(1) << tags_q[rd_q] : '0;
      dat_d = pop ? mem_rd_data : dat_q;
      err_d = err_q | (mem_rd_valid & (cnt_q == '0));
   end

   assign mem_rd_en   = win;
   assign mem_rd_addr = win ? ch_rd_addr[int'(win_id)*ADDR_W +: ADDR_W] : '0;
   assign ch_rd_ready = accept ? NUM_CH'(1) << win_id : '0;
   assign ch_rd_valid = vld_q;
   assign ch_rd_data  = dat_q;
   assign outstanding = cnt_q;
   assign resp_err    = err_q;

   // control state; reset forgets every in-flight read
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q  <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         vld_q <= '0;
         dat_q <= '0;
         err_q <= 1'b0;
      end else begin
         rr_q  <= rr_d;
         wr_q  <= wr_q + PW'(accept);
         rd_q  <= rd_q + PW'(pop);
         cnt_q <= cnt_d;
         vld_q <= vld_d;
         dat_q <= dat_d;
         err_q <= err_d;
      end
   end

   // tag storage needs no reset: an entry is only read after it was written
   always_ff @(posedge clk) begin
      if (accept) tags_q[wr_q] <= win_id;
   end
endmodule

// File: tb/tb_memory_read_arbiter.sv
// tb_memory_read_arbiter: directed vector table, reset corner sequence and randomized run against a queue-based model
module tb_memory_read_arbiter;
   localparam int NCH = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MO  = 4;
   localparam logic [31:0] A0 = 32'h100;
   localparam logic [31:0] A1 = 32'h200;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    ch_rd_en;
   logic [63:0]   ch_rd_addr;
   logic [1:0]    ch_rd_ready;
   logic [31:0]   ch_rd_data;
   logic [1:0]    ch_rd_valid;
   logic          mem_rd_en;
   logic [31:0]   mem_rd_addr;
   logic          mem_rd_ready;
   logic [31:0]   mem_rd_data;
   logic          mem_rd_valid;
   logic [2:0]    outstanding;
   logic          resp_err;

   int n_tests = 0;
   int n_fail  = 0;

   int          mq[$];
   int          m_rr;
   logic [1:0]  m_vld;
   logic [31:0] m_dat;
   logic        m_err;

   typedef struct {
      logic        r;
      logic [1:0]  en;
      logic        rdy;
      logic        mv;
      logic [31:0] md;
      logic [1:0]  e_rdy;
      logic        e_men;
      logic [31:0] e_addr;
      logic [1:0]  e_vld;
      logic [31:0] e_dat;
      logic [2:0]  e_out;
      logic        e_err;
   } vec_t;
   vec_t tbl[$];

   memory_read_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .rst(rst), .ch_rd_en(ch_rd_en), .ch_rd_addr(ch_rd_addr),
      .ch_rd_ready(ch_rd_ready), .ch_rd_data(ch_rd_data), .ch_rd_valid(ch_rd_valid),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .outstanding(outstanding), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1,
                        input logic rdy, input logic mv, input logic [31:0] md);
      rst = r;
      ch_rd_en = en;
      ch_rd_addr = {a1, a0};
      mem_rd_ready = rdy;
      mem_rd_valid = mv;
      mem_rd_data = md;
      #1;
   endtask

   function automatic int winner();
      if (mq.size() == MO) return -1;
      for (int k = 0; k < NCH; k++)
         if (ch_rd_en[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
      return -1;
   endfunction

   task automatic model_update();
      int w;
      int h;
      bit was_empty;
      if (rst) begin
         mq.delete();
         m_rr = 0;
         m_vld = 2'b00;
         m_dat = '0;
         m_err = 1'b0;
      end else begin
         w = winner();
         was_empty = mq.size() == 0;
         m_vld = 2'b00;
         if (mem_rd_valid && was_empty) m_err = 1'b1;
         if (mem_rd_valid && !was_empty) begin
            h = mq.pop_front();
            m_vld = 2'(1 << h);
            m_dat = mem_rd_data;
         end
         if (w >= 0 && mem_rd_ready) begin
            mq.push_back(w);
            m_rr = (w + 1) % NCH;
         end
      end
   endtask

   task automatic model_check(input int cyc);
      int w;
      logic [1:0]  e_rdy;
      logic [31:0] e_addr;
      w = winner();
      e_rdy = (w >= 0 && mem_rd_ready) ? 2'(1 << w) : 2'b00;
      e_addr = (w >= 0) ? ch_rd_addr[w*AW +: AW] : 32'h0;
      chk($sformatf("rnd%0d ch_rd_ready", cyc), 64'(ch_rd_ready), 64'(e_rdy));
      chk($sformatf("rnd%0d mem_rd_en", cyc), 64'(mem_rd_en), 64'(w >= 0));
      chk($sformatf("rnd%0d mem_rd_addr", cyc), 64'(mem_rd_addr), 64'(e_addr));
      chk($sformatf("rnd%0d ch_rd_valid", cyc), 64'(ch_rd_valid), 64'(m_vld));
      chk($sformatf("rnd%0d ch_rd_data", cyc), 64'(ch_rd_data), 64'(m_dat));
      chk($sformatf("rnd%0d outstanding", cyc), 64'(outstanding), 64'(mq.size()));
      chk($sformatf("rnd%0d resp_err", cyc), 64'(resp_err), 64'(m_err));
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic r, input logic [1:0] en, input logic rdy, input logic mv, input logic [31:0] md,
                      input logic [1:0] e_rdy, input logic e_men, input logic [31:0] e_addr,
                      input logic [1:0] e_vld, input logic [31:0] e_dat, input logic [2:0] e_out, input logic e_err);
      vec_t v;
      v.r = r; v.en = en; v.rdy = rdy; v.mv = mv; v.md = md;
      v.e_rdy = e_rdy; v.e_men = e_men; v.e_addr = e_addr;
      v.e_vld = e_vld; v.e_dat = e_dat; v.e_out = e_out; v.e_err = e_err;
      tbl.push_back(v);
   endtask

   initial begin
      add(1'b1, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        3'd0, 1'b0);
      add(1'b0, 2'b01, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, A0,    2'b00, 32'h0,        3'd0, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        3'd1, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        3'd1, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 2'b01, 32'hDEADBEEF, 3'd0, 1'b0);
      add(1'b1, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 2'b00, 32'hDEADBEEF, 3'd0, 1'b0);
      add(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, A0,    2'b00, 32'h0,        3'd0, 1'b0);
      add(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, A1,    2'b00, 32'h0,        3'd1, 1'b0);
      add(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b01, 1'b1, A0,    2'b00, 32'h0,        3'd2, 1'b0);
      add(1'b0, 2'b11, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, A1,    2'b00, 32'h0,        3'd3, 1'b0);
      add(1'b0, 2'b11, 1'b1, 1'b1, 32'hD0D0D0D0, 2'b00, 1'b0, 32'h0, 2'b00, 32'h0,        3'd4, 1'b0);
      add(1'b0, 2'b11, 1'b1, 1'b1, 32'hD1D1D1D1, 2'b01, 1'b1, A0,    2'b01, 32'hD0D0D0D0, 3'd3, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b1, 32'hD2D2D2D2, 2'b00, 1'b0, 32'h0, 2'b10, 32'hD1D1D1D1, 3'd3, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b1, 32'hD3D3D3D3, 2'b00, 1'b0, 32'h0, 2'b01, 32'hD2D2D2D2, 3'd2, 1'b0);
      add(1'b0, 2'b10, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, A1,    2'b10, 32'hD3D3D3D3, 3'd1, 1'b0);
      add(1'b0, 2'b01, 1'b1, 1'b1, 32'h5555AAAA, 2'b01, 1'b1, A0,    2'b00, 32'hD3D3D3D3, 3'd2, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b1, 32'h12345678, 2'b00, 1'b0, 32'h0, 2'b01, 32'h5555AAAA, 3'd2, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b1, 32'h0BADF00D, 2'b00, 1'b0, 32'h0, 2'b10, 32'h12345678, 3'd1, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b1, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h0, 2'b01, 32'h0BADF00D, 3'd0, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 2'b00, 32'h0BADF00D, 3'd0, 1'b1);
      add(1'b0, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 2'b00, 32'h0BADF00D, 3'd0, 1'b1);
      add(1'b0, 2'b01, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, A0,    2'b00, 32'h0BADF00D, 3'd0, 1'b1);
      add(1'b0, 2'b11, 1'b0, 1'b0, 32'h0,        2'b00, 1'b1, A1,    2'b00, 32'h0BADF00D, 3'd0, 1'b1);
      add(1'b0, 2'b01, 1'b1, 1'b1, 32'h77,       2'b01, 1'b1, A0,    2'b00, 32'h0BADF00D, 3'd0, 1'b1);
      add(1'b0, 2'b00, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0, 2'b00, 32'h0BADF00D, 3'd1, 1'b1);

      drive(1'b1, 2'b00, A0, A1, 1'b0, 1'b0, 32'h0);
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].en, A0, A1, tbl[i].rdy, tbl[i].mv, tbl[i].md);
         chk($sformatf("vec%0d ch_rd_ready", i), 64'(ch_rd_ready), 64'(tbl[i].e_rdy));
         chk($sformatf("vec%0d mem_rd_en", i), 64'(mem_rd_en), 64'(tbl[i].e_men));
         chk($sformatf("vec%0d mem_rd_addr", i), 64'(mem_rd_addr), 64'(tbl[i].e_addr));
         chk($sformatf("vec%0d ch_rd_valid", i), 64'(ch_rd_valid), 64'(tbl[i].e_vld));
         chk($sformatf("vec%0d ch_rd_data", i), 64'(ch_rd_data), 64'(tbl[i].e_dat));
         chk($sformatf("vec%0d outstanding", i), 64'(outstanding), 64'(tbl[i].e_out));
         chk($sformatf("vec%0d resp_err", i), 64'(resp_err), 64'(tbl[i].e_err));
         tick();
      end

      drive(1'b0, 2'b11, A0, A1, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b0, 2'b11, A0, A1, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b0, 2'b00, A0, A1, 1'b1, 1'b0, 32'h0);
      chk("midrst outstanding_before", 64'(outstanding), 64'd3);
      tick();
      drive(1'b1, 2'b11, A0, A1, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b0, 2'b11, A0, A1, 1'b1, 1'b1, 32'hAB);
      chk("midrst outstanding_after", 64'(outstanding), 64'd0);
      chk("midrst ch_rd_valid", 64'(ch_rd_valid), 64'd0);
      chk("midrst resp_err_cleared", 64'(resp_err), 64'd0);
      chk("midrst ch0_wins_first", 64'(ch_rd_ready), 64'b01);
      chk("midrst mem_rd_addr", 64'(mem_rd_addr), 64'(A0));
      tick();
      drive(1'b0, 2'b00, A0, A1, 1'b1, 1'b0, 32'h0);
      chk("postrst stale_resp_err", 64'(resp_err), 64'd1);
      chk("postrst ch_rd_valid", 64'(ch_rd_valid), 64'd0);
      chk("postrst outstanding", 64'(outstanding), 64'd1);
      tick();

      drive(1'b1, 2'b00, A0, A1, 1'b0, 1'b0, 32'h0);
      tick();
      for (int c = 0; c < 600; c++) begin
         logic mv;
         mv = (mq.size() > 0) ? 1'($urandom % 2) : 1'($urandom % 40 == 0);
         drive(1'($urandom % 80 == 0), 2'($urandom), $urandom, $urandom,
               1'($urandom % 4 != 0), mv, $urandom);
         model_check(c);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
